// File: rtl/rf_bypass_sb_pkg.sv
// Shared defaults, select-width helper and register index type for the
// decode-stage register file with pending-write scoreboard.
package rf_bypass_sb_pkg;
    localparam int DEF_DATA_W   = 16;
    localparam int DEF_NUM_REGS = 8;
    localparam int DEF_NUM_RD   = 2;

    function automatic int sel_w(input int num_regs);
        return (num_regs < 2) ? 1 : $clog2(num_regs);
    endfunction

    typedef logic [$clog2(DEF_NUM_REGS)-1:0] reg_idx_t;
endpackage

// File: rtl/rf_bypass_rdport.sv
// One combinational read port: stored value or forwarded write data, plus
// the busy bit of the selected register.
module rf_bypass_rdport
    import rf_bypass_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    parameter int SEL_W    = sel_w(NUM_REGS)
) (
    input  logic [SEL_W-1:0]                rd_sel,
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic                            fwd_en,
    input  logic [SEL_W-1:0]                wr_sel,
    input  logic [DATA_W-1:0]               wr_data,
    input  logic [NUM_REGS-1:0]             busy_vec,
    output logic [DATA_W-1:0]               rd_data,
    output logic                            rd_busy
);
    localparam logic [SEL_W:0] NUM_REGS_L = (SEL_W+1)'(NUM_REGS);

    logic in_range;
    logic zero_forced;
    logic fwd_hit;

    always_comb begin
        in_range    = {1'b0, rd_sel} < NUM_REGS_L;
        zero_forced = (ZERO_REG != 0) && (rd_sel == '0);
        fwd_hit     = (BYPASS != 0) && fwd_en && (wr_sel == rd_sel) && in_range && !zero_forced;
        rd_data     = '0;
        rd_busy     = 1'b0;
        // A forwarded write retires its producer, so busy reads clear.
        if (fwd_hit) begin
            rd_data = wr_data;
        end else if (in_range && !zero_forced) begin
            rd_data = regs[rd_sel];
            rd_busy = busy_vec[rd_sel];
        end
    end
endmodule

// File: rtl/rf_bypass_sb.sv
// Parametrised bypassed register file with per-register busy scoreboard and
// a sticky hazard/range error flag.
module rf_bypass_sb
    import rf_bypass_sb_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int NUM_REGS = DEF_NUM_REGS,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0,
    parameter int SEL_W    = sel_w(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_RD*SEL_W-1:0]  rd_sel,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     wr_en,
    input  logic [SEL_W-1:0]         wr_sel,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     issue_en,
    input  logic [SEL_W-1:0]         issue_sel,
    output logic [NUM_REGS-1:0]      busy_vec,
    output logic                     err
);
    localparam logic [SEL_W:0] NUM_REGS_L = (SEL_W+1)'(NUM_REGS);

    logic [NUM_REGS-1:0][DATA_W-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]             busy_q, busy_d;
    logic                            err_q, err_d;

    logic wr_in_range, iss_in_range;
    logic wr_ok, iss_ok, waw_hazard;

    always_comb begin
        wr_in_range  = {1'b0, wr_sel} < NUM_REGS_L;
        iss_in_range = {1'b0, issue_sel} < NUM_REGS_L;
        wr_ok        = wr_en && wr_in_range && !((ZERO_REG != 0) && (wr_sel == '0));
        iss_ok       = issue_en && iss_in_range && !((ZERO_REG != 0) && (issue_sel == '0));
        // A write retiring the old producer in the same cycle is a legal re-issue.
        waw_hazard   = issue_en && iss_in_range && busy_q[issue_sel] &&
                       !(wr_en && (wr_sel == issue_sel));

        regs_d = regs_q;
        busy_d = busy_q;
        err_d  = err_q;
        if (wr_ok) begin
            regs_d[wr_sel] = wr_data;
            busy_d[wr_sel] = 1'b0;
        end
        if (iss_ok) begin
            busy_d[issue_sel] = 1'b1;
        end
        if (waw_hazard || (issue_en && !iss_in_range) || (wr_en && !wr_in_range)) begin
            err_d = 1'b1;
        end
        if (!rst) begin
            regs_d = '0;
            busy_d = '0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        regs_q <= regs_d;
        busy_q <= busy_d;
        err_q  <= err_d;
    end

    assign busy_vec = busy_q;
    assign err      = err_q;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        rf_bypass_rdport #(
            .DATA_W   (DATA_W),
            .NUM_REGS (NUM_REGS),
            .BYPASS   (BYPASS),
            .ZERO_REG (ZERO_REG),
            .SEL_W    (SEL_W)
        ) u_rdport (
            .rd_sel   (rd_sel[i*SEL_W +: SEL_W]),
            .regs     (regs_q),
            .fwd_en   (rst & wr_en),
            .wr_sel   (wr_sel),
            .wr_data  (wr_data),
            .busy_vec (busy_q),
            .rd_data  (rd_data[i*DATA_W +: DATA_W]),
            .rd_busy  (rd_busy[i])
        );
    end
endmodule

// File: doc/rf_bypass_sb.md
Name: rf_bypass_sb

Overview:
- Parametrised successor to the two-read/one-write bypassed register file used in decode.
- Generalised in data width, register count and number of read ports.
- Adds an optional hardwired-zero register and a per-register pending-write scoreboard (busy bits) for decode-stage hazard detection.
- Adds a sticky registered error flag.
- Sits in decode; the writeback stage drives the write port, and issue logic marks destination registers busy.

Parameters:
- DATA_W, 16, data width of each register.
- NUM_REGS, 8, number of architectural registers (at least 2). SEL_W = clog2(NUM_REGS).
- NUM_RD, 2, number of read ports (1 to 4).
- BYPASS, 1, 1 = same-cycle write data is forwarded to matching read ports; 0 = reads return stored value only.
- ZERO_REG, 0, 1 = register 0 always reads 0, ignores writes and is never busy.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-low (asserted when 0).
- rd_sel  in  NUM_RD*SEL_W  read selects; port i occupies bits [i*SEL_W +: SEL_W].
- rd_data  out  NUM_RD*DATA_W  read data, combinational; port i occupies bits [i*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  1 = the register on port i has an outstanding producer.
- wr_en  in  1  write strobe.
- wr_sel  in  SEL_W  write register.
- wr_data  in  DATA_W  write data.
- issue_en  in  1  marks issue_sel busy.
- issue_sel  in  SEL_W  destination of the issuing instruction.
- busy_vec  out  NUM_REGS  registered busy bits.
- err  out  1  sticky error, registered.

Behaviour:
- Storage:
  - NUM_REGS x DATA_W flops, written at the rising edge when rst=1 and wr_en=1.
  - A write to wr_sel >= NUM_REGS is dropped.
- Reset: on a rising edge with rst=0, all registers, busy_vec and err are cleared to 0. Issues and writes in that cycle are ignored.
- Read path (combinational, zero latency):
  - rd_data[i] = wr_data when BYPASS=1, rst=1, wr_en=1, wr_sel==rd_sel[i] and the register is not zero-forced.
  - Otherwise rd_data[i] = reg[rd_sel[i]].
  - rd_sel >= NUM_REGS reads 0.
  - With ZERO_REG=1, register 0 always reads 0, including when bypass conditions match.
- rd_busy[i] = busy_vec[rd_sel[i]], except it reads 0 when BYPASS=1 and a matching write is forwarded in the same cycle. An out-of-range select also gives rd_busy=0.
- Busy update per register r at the edge, with rst=1:
  - set if issue_en and issue_sel==r;
  - else clear if wr_en and wr_sel==r;
  - else hold.
  - Issue and write to the same register in the same cycle leaves the bit at 1 (new producer wins).
  - Issue in cycle N is visible on busy_vec and rd_busy from cycle N+1. It never affects same-cycle reads.
  - With ZERO_REG=1, register 0 never sets busy.
- A write to a non-busy register is legal (e.g. initialisation). Data is written, busy stays 0, no error.
- err is set at the edge, when rst=1, on any of:
  - issue_en with busy_vec[issue_sel]=1 and no same-cycle write clearing it (WAW hazard);
  - issue_sel >= NUM_REGS with issue_en;
  - wr_sel >= NUM_REGS with wr_en.
- err holds until reset. The offending issue still sets busy if in range.
- Simultaneous writes to different registers from one port are impossible (single write port). Multiple read ports may select the same register and receive identical data and busy values.

Decomposition:
- Shared package holds:
  - default DATA_W/NUM_REGS/NUM_RD constants;
  - a SEL_W helper function (clog2);
  - a typedef for the register index.
- Sub-module rf_bypass_rdport: one read port. Inputs are the select, the storage array view, the write bypass signals and busy_vec; outputs are rd_data[i] and rd_busy[i]. It is instantiated NUM_RD times in a generate loop.
- Top level holds the storage, the busy flops and the err logic.

Test Plan:
- Reset then read all registers -> rd_data=0x0000, busy_vec=0, err=0. Assert rst=0 while wr_en=1 to reg 3 with 0xBEEF -> reg 3 still 0 after release.
- Write reg 5=0x1234, same cycle rd_sel[0]=5 with BYPASS=1 -> rd_data[0]=0x1234 combinationally. Repeat with BYPASS=0 -> old value 0x0000, then 0x1234 next cycle.
- issue_en reg 2 in cycle N -> busy_vec[2]=1 and rd_busy=1 for port reading 2 from N+1. wr_en reg 2 = 0x00AA at N+3 -> rd_busy=0 (bypass) in N+3 and busy_vec[2]=0 at N+4.
- Issue reg 4 twice without a write -> err=1 after the second edge, sticky through later traffic until rst=0. Issue reg 4 while writing reg 4 in the same cycle -> busy stays 1, err stays 0.
- ZERO_REG=1: write 0xFFFF to reg 0 and issue reg 0 -> reads 0, busy_vec[0]=0, err=0.
- NUM_REGS=6, NUM_RD=3: wr_sel=7 -> write dropped, err=1. All three ports read reg 1 = 0x5A5A simultaneously -> identical data on all ports.
